// File: rtl/shift_add_sequencer_if.sv
// Handshake, configuration and result signals of the shift-and-add sequencer.
// The master modport is the producer/consumer side; the slave modport is the sequencer.
interface shift_add_sequencer_if #(
    parameter int WIDTH = 21,
    parameter int IDX_W = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    base_en;

    logic                    cfg_we;
    logic [IDX_W-1:0]        cfg_idx;
    logic                    cfg_en;
    logic                    cfg_dir;
    logic                    cfg_sub;
    logic [3:0]              cfg_shamt;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_sat;
    logic                    out_err;

    modport master (
        output in_valid, in_data, base_en,
        output cfg_we, cfg_idx, cfg_en, cfg_dir, cfg_sub, cfg_shamt,
        output out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_data, base_en,
        input  cfg_we, cfg_idx, cfg_en, cfg_dir, cfg_sub, cfg_shamt,
        input  out_ready,
        output in_ready, out_valid, out_data, out_sat, out_err
    );
endinterface

// File: rtl/shift_add_sequencer.sv
// Evaluates y = base + sum(+/- a shifted by k_i), one configured term per clock,
// reusing a single shifter and a single saturating adder.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// RUN   | applying term slot idx, MAX_TERMS cycles regardless of enables
// DONE  | out_valid high, result held until out_ready
module shift_add_sequencer #(
    parameter int WIDTH     = 21,
    parameter int MAX_TERMS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic       en;
        logic       dir;
        logic       sub;
        logic [3:0] shamt;
    } slot_t;

    localparam int LW = WIDTH + 16;
    localparam logic signed [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    slot_t stg [MAX_TERMS];
    slot_t act [MAX_TERMS];

    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] acc_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    sat_q;
    logic                    err_q;
    logic signed [WIDTH-1:0] out_data_q;
    logic                    out_sat_q;
    logic                    out_err_q;

    logic accept;
    logic last;
    logic in_ready;
    logic out_valid;

    slot_t                   cur;
    logic                    legal;
    logic signed [LW-1:0]    wide;
    logic signed [WIDTH-1:0] term;
    logic                    term_sat;
    logic                    term_err;
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] acc_next;
    logic                    sum_sat;

    assign accept = bus.in_valid && in_ready;
    assign last   = (idx_q == IDX_W'(MAX_TERMS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Term unit: shifts the latched operand, never the accumulator.
    always_comb begin
        cur      = act[idx_q];
        term     = '0;
        term_sat = 1'b0;
        term_err = 1'b0;
        wide     = '0;
        case (cur.shamt)
            4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        if (cur.en) begin
            if (!legal) begin
                term_err = 1'b1;
            end else if (cur.dir) begin
                term = a_q >>> cur.shamt;
            end else begin
                wide = {{(LW-WIDTH){a_q[WIDTH-1]}}, a_q} <<< cur.shamt;
                if (wide[LW-1:WIDTH-1] != {(LW-WIDTH+1){wide[LW-1]}}) begin
                    term_sat = 1'b1;
                    term     = wide[LW-1] ? VMIN : VMAX;
                end else begin
                    term = wide[WIDTH-1:0];
                end
            end
        end
    end

    // One guard bit is enough: both operands are WIDTH-bit values.
    always_comb begin
        if (cur.en && cur.sub) begin
            sum = {acc_q[WIDTH-1], acc_q} - {term[WIDTH-1], term};
        end else begin
            sum = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};
        end
        sum_sat  = (sum[WIDTH] != sum[WIDTH-1]);
        acc_next = sum_sat ? (sum[WIDTH] ? VMIN : VMAX) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TERMS; i++) begin
                stg[i] <= '0;
                act[i] <= '0;
            end
            a_q        <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                stg[bus.cfg_idx] <= '{en: bus.cfg_en, dir: bus.cfg_dir,
                                      sub: bus.cfg_sub, shamt: bus.cfg_shamt};
            end
            // Snapshot takes the pre-write staging value on a coincident write.
            if (accept) begin
                a_q   <= bus.in_data;
                acc_q <= bus.base_en ? bus.in_data : '0;
                for (int i = 0; i < MAX_TERMS; i++) begin
                    act[i] <= stg[i];
                end
                idx_q <= '0;
                sat_q <= 1'b0;
                err_q <= 1'b0;
            end else if (state_q == RUN) begin
                acc_q <= acc_next;
                sat_q <= sat_q | term_sat | sum_sat;
                err_q <= err_q | term_err;
                idx_q <= idx_q + IDX_W'(1);
                if (last) begin
                    out_data_q <= acc_next;
                    out_sat_q  <= sat_q | term_sat | sum_sat;
                    out_err_q  <= err_q | term_err;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_shift_add_sequencer.sv
// Directed bench for shift_add_sequencer with hand-computed expected results.
module tb_shift_add_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;
    logic signed [20:0] held;

    shift_add_sequencer_if #(.WIDTH(21), .IDX_W(2)) bus ();

    shift_add_sequencer #(.WIDTH(21), .MAX_TERMS(4), .IDX_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int idx, input logic en, input logic dir,
                       input logic sub, input logic [3:0] sh);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'(idx);
        bus.cfg_en    = en;
        bus.cfg_dir   = dir;
        bus.cfg_sub   = sub;
        bus.cfg_shamt = sh;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 4; i++) cfg(i, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic start(input logic signed [20:0] a, input logic b);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(bus.in_ready), 1);
        bus.in_data  = a;
        bus.base_en  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop_after_hs", 32'(bus.out_valid), 0);
        chk("in_ready_after_hs", 32'(bus.in_ready), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.base_en   = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_en    = 1'b0;
        bus.cfg_dir   = 1'b0;
        bus.cfg_sub   = 1'b0;
        bus.cfg_shamt = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_sat", 32'(bus.out_sat), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Leak: 800 - 800>>>3 = 700, four clocks after accept.
        cfg(0, 1'b1, 1'b1, 1'b1, 4'd3);
        start(21'sd800, 1'b1);
        wait_done(lat);
        chk("leak_latency", lat, 4);
        chk("leak_data", 32'(bus.out_data), 700);
        chk("leak_sat", 32'(bus.out_sat), 0);
        chk("leak_err", 32'(bus.out_err), 0);
        consume();

        // Floor on negative: -800>>>6 = -13; then -(-800>>>3) = +100.
        cfg(0, 1'b1, 1'b1, 1'b0, 4'd6);
        start(-21'sd800, 1'b1);
        wait_done(lat);
        chk("negfloor_latency", lat, 4);
        chk("negfloor_data", 32'(bus.out_data), -813);
        consume();
        cfg(1, 1'b1, 1'b1, 1'b1, 4'd3);
        start(-21'sd800, 1'b1);
        wait_done(lat);
        chk("negfloor2_data", 32'(bus.out_data), -713);
        chk("negfloor2_sat", 32'(bus.out_sat), 0);
        consume();
        clear_cfg();

        // Left-shift clamp: 200000<<3 = 1600000 -> 1048575.
        cfg(0, 1'b1, 1'b0, 1'b0, 4'd3);
        start(21'sd200000, 1'b1);
        wait_done(lat);
        chk("sat_data", 32'(bus.out_data), 1048575);
        chk("sat_flag", 32'(bus.out_sat), 1);
        chk("sat_err", 32'(bus.out_err), 0);
        consume();

        // 0 - (-131072<<3) = 0 - (-1048576) -> clamps to 1048575.
        cfg(0, 1'b1, 1'b0, 1'b1, 4'd3);
        start(-21'sd131072, 1'b0);
        wait_done(lat);
        chk("submin_data", 32'(bus.out_data), 1048575);
        chk("submin_sat", 32'(bus.out_sat), 1);
        consume();

        // Illegal shamt 5 contributes nothing but flags an error while enabled.
        cfg(0, 1'b1, 1'b1, 1'b0, 4'd5);
        start(21'sd640, 1'b1);
        wait_done(lat);
        chk("illegal_data", 32'(bus.out_data), 640);
        chk("illegal_err", 32'(bus.out_err), 1);
        chk("illegal_sat", 32'(bus.out_sat), 0);
        consume();
        cfg(0, 1'b0, 1'b1, 1'b0, 4'd5);
        start(21'sd640, 1'b1);
        wait_done(lat);
        chk("disabled_data", 32'(bus.out_data), 640);
        chk("disabled_err", 32'(bus.out_err), 0);
        consume();

        // Write during RUN must not affect this run; backpressure holds outputs.
        cfg(0, 1'b1, 1'b1, 1'b1, 4'd3);
        start(21'sd800, 1'b1);
        cfg(0, 1'b1, 1'b1, 1'b1, 4'd4);
        wait_done(lat);
        chk("shadow_cur_data", 32'(bus.out_data), 700);
        held = 21'sd700;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 32'(held));
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_flags", 32'({bus.out_sat, bus.out_err}), 0);
        end
        consume();
        chk("retain_data", 32'(bus.out_data), 700);
        start(21'sd800, 1'b1);
        wait_done(lat);
        chk("shadow_next_data", 32'(bus.out_data), 750);
        consume();

        // Reset on the second RUN cycle clears outputs and staging.
        start(21'sd800, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        start(21'sd800, 1'b1);
        wait_done(lat);
        chk("postrst_latency", lat, 4);
        chk("postrst_data", 32'(bus.out_data), 800);
        chk("postrst_sat", 32'(bus.out_sat), 0);
        chk("postrst_err", 32'(bus.out_err), 0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_add_sequencer.md
Name: shift_add_sequencer

Overview:
- Multi-cycle controller that evaluates a programmable shift-and-add expression on one 21-bit signed neuron quantity (e.g. leak: v - v>>>3 - v>>>6). The expression is y = base + sum of ±(a shifted by k_i).
- Applies one term per clock from a small configuration table, so one shift unit and one adder are reused instead of a multiplier.
- Sits between the membrane-potential register stage and the threshold compare, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 21, data width (two's complement).
- MAX_TERMS, 4, number of term slots; fixed RUN length.
- IDX_W, 2, width of cfg_idx (clog2(MAX_TERMS)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- in_data  in  WIDTH  signed operand a.
- base_en  in  1  sampled at accept; 1: acc starts at a, 0: acc starts at 0.
- cfg_we  in  1  write one staging slot.
- cfg_idx  in  IDX_W  slot index.
- cfg_en  in  1  slot enable.
- cfg_dir  in  1  1 = right shift (arithmetic), 0 = left shift.
- cfg_sub  in  1  1 = subtract term, 0 = add.
- cfg_shamt  in  4  shift amount.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  signed result.
- out_sat  out  1  saturation occurred in this evaluation.
- out_err  out  1  an enabled slot used an illegal shift amount.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, out_data=0, out_sat=0, out_err=0.
  - All staging and active slots cleared (en=0, dir=0, sub=0, shamt=0). in_ready=1 once reset releases.
- States:
  - IDLE: in_ready=1. Accept occurs on in_valid&in_ready.
  - RUN: idx counts 0..MAX_TERMS-1.
  - DONE: out_valid=1.
- Accept edge:
  - latch a; acc = base_en ? a : 0.
  - Copy staging table into active table (snapshot); clear sticky sat/err; idx=0; go RUN.
- RUN, each edge:
  - acc = sat(acc ± term(active[idx])).
  - If idx==MAX_TERMS-1, go DONE and drive out_data=acc; else idx++.
  - Fixed cost of MAX_TERMS edges whether or not slots are enabled; a disabled slot adds 0.
- Latency: out_valid rises exactly MAX_TERMS clocks after the accept edge (4 by default).
- Term computation:
  - Legal shamt set {3,4,6,7,8,9}, both directions. Any other value on an enabled slot gives term=0 and sets out_err.
  - Right shift: arithmetic (sign fill), i.e. floor division by 2^k.
  - Left shift: evaluated at full precision and clamped to [-2^20, 2^20-1]; a clamp sets out_sat.
- Add/sub:
  - Computed at WIDTH+1 bits, then clamped to [-1048576, 1048575]; a clamp sets out_sat.
  - Subtracting -1048576 saturates to 1048575.
- DONE:
  - out_valid, out_data, out_sat and out_err hold stable until out_valid&out_ready.
  - On that edge: out_valid=0, go IDLE. in_ready goes high the following cycle; there is no same-cycle re-accept.
  - out_data retains its last value after the handshake.
- Config writes:
  - Accepted in any state and update the staging table only.
  - A write on the same edge as an accept is not seen by that evaluation (the snapshot takes the old value) but is seen by the next one.
  - A write during RUN or DONE does not affect the running evaluation.
- in_valid while not IDLE: ignored; the operand stays pending upstream.
- Reset mid-RUN or mid-DONE: outputs drop to reset values immediately; no partial result is ever presented.

Test Plan:
- Leak: slot0={en,right,sub,3}, others off, base_en=1, a=800 -> out_data=700, out_valid exactly 4 cycles after accept, sat=0, err=0.
- Negative floor: slot0={en,right,add,6}, base_en=1, a=-800 -> -800 + (-13) = -813; slot1={en,right,sub,3} added -> -813 - (-100) = -713.
- Saturation: slot0={en,left,add,3}, base_en=1, a=200000 -> out_data=1048575, out_sat=1.
- Illegal shift: slot0={en,right,add,5}, base_en=1, a=640 -> out_data=640, out_err=1. Same slot with en=0 -> out_err=0.
- Backpressure/shadowing:
  - Hold out_ready=0 for 10 cycles; out_data, out_valid and flags stay stable and in_ready stays 0.
  - Write slot0 shamt=4 during RUN; the current result uses 3, and the next evaluation of a=800 gives 750.
- Reset mid-RUN: drop rst_n on the 2nd RUN cycle -> out_valid=0 immediately, staging cleared. After release, in_ready=1 and a=800 with base_en=1 gives out_data=800.
